// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the PC register update (pc_en/next_pc), issues one
// imem request per PC with at most one outstanding, and hands fetched words to
// decode over valid/ready. Redirects override all other PC updates and drop any
// response still in flight for the old PC.
// Optional feature macro: FETCH_TIMEOUT_EN adds a response timeout, a sticky
// fetch_fault output and a HALT state that only reset_n can leave.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] PC_STEP        = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    DRAIN
`ifdef FETCH_TIMEOUT_EN
    ,
    HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        redirect_take;
  logic        outstanding;
  logic        timeout_hit;
  logic        fault_set;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fault_q, fault_d;

  // Redirects are ignored once halted.
  assign redirect_take = redirect_valid && (state_q != HALT);
  assign timeout_hit   = (tmo_cnt_q == TIMEOUT_LAST);

  // Response timeout counter: restarts on every state change, counts while waiting.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT || state_q == DRAIN) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Sticky fault: set once by a timeout, cleared only by reset.
  always_comb begin
    fault_d = fault_q | fault_set;
  end

  // Timeout counter and fault registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign redirect_take = redirect_valid;
  assign timeout_hit   = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

  // A request remains outstanding after this cycle if one was accepted or one
  // is still awaiting its response.
  assign outstanding = ((state_q == WAIT || state_q == DRAIN) && !imem_rsp_valid) ||
                       (state_q == REQ && imem_req_ready);

  // Next-state, PC update and instruction-register logic.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    next_pc      = pc;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    fault_set    = 1'b0;
    if (reset_n) begin
      case (state_q)
        BOOT: begin
          pc_en   = 1'b1;
          next_pc = RESET_PC;
          state_d = REQ;
        end
        REQ: begin
          if (imem_req_ready) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_valid_d = 1'b1;
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = pc;
            pc_en        = 1'b1;
            next_pc      = pc + PC_STEP;
            state_d      = HOLD;
          end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
            fault_set = 1'b1;
            state_d   = HALT;
`endif
          end
        end
        HOLD: begin
          if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
          end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
            fault_set = 1'b1;
            state_d   = HALT;
`endif
          end
        end
`ifdef FETCH_TIMEOUT_EN
        HALT: begin
          state_d = HALT;
        end
`endif
        default: begin
          state_d = BOOT;
        end
      endcase

      // Redirect overrides everything above: the instruction registers keep
      // their old contents, only the valid flag drops.
      if (redirect_take) begin
        pc_en        = 1'b1;
        next_pc      = redirect_pc;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        fault_set    = 1'b0;
        state_d      = outstanding ? DRAIN : REQ;
      end
    end
  end

  // State and instruction output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req_valid = reset_n && (state_q == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. The PC register is modelled in the
// bench; imem and decode handshakes are driven cycle by cycle with
// hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc = '0;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(
    .RESET_PC      (32'h0000_0100),
    .PC_STEP       (32'd4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .pc_en         (pc_en),
    .next_pc       (next_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // Program counter register model.
  always @(posedge clk) begin
    if (pc_en) pc <= next_pc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    step();
    step();

    // Reset state
    #1;
    check("rst_pc_en", pc_en, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", fetch_fault, 0);

    // Boot: load RESET_PC, then request at it
    reset_n = 1'b1;
    #1;
    check("boot_pc_en", pc_en, 1);
    check("boot_next_pc", next_pc, 32'h100);
    check("boot_req_valid", imem_req_valid, 0);
    step();
    check("req0_valid", imem_req_valid, 1);
    check("req0_addr", imem_req_addr, 32'h100);
    check("req0_pc_en", pc_en, 0);

    // Response while in REQ is ignored
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_5555;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check("req_ign_valid", imem_req_valid, 1);
    check("req_ign_inst_valid", inst_valid, 0);

    // Normal fetch, decode ready
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    inst_ready     = 1'b1;
    #1;
    check("wait_req_valid", imem_req_valid, 0);
    check("rsp_pc_en", pc_en, 1);
    check("rsp_next_pc", next_pc, 32'h104);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check("f1_inst_valid", inst_valid, 1);
    check("f1_inst_data", inst_data, 32'hDEAD_BEEF);
    check("f1_inst_pc", inst_pc, 32'h100);
    check("f1_hold_req", imem_req_valid, 0);
    step();
    check("req1_valid", imem_req_valid, 1);
    check("req1_addr", imem_req_addr, 32'h104);
    check("req1_inst_valid", inst_valid, 0);

    // Decode stall in HOLD for 5 cycles
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_inst_valid", inst_valid, 1);
      check("stall_inst_data", inst_data, 32'hCAFE_F00D);
      check("stall_req_valid", imem_req_valid, 0);
      step();
    end
    check("stall_inst_pc", inst_pc, 32'h104);
    inst_ready = 1'b1;
    step();
    check("req2_addr", imem_req_addr, 32'h108);
    check("req2_valid", imem_req_valid, 1);
    check("req2_inst_valid", inst_valid, 0);

    // Redirect in WAIT without response -> DRAIN drops the next response
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    #1;
    check("rdw_pc_en", pc_en, 1);
    check("rdw_next_pc", next_pc, 32'h2000);
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    #1;
    check("drain_pc_en", pc_en, 0);
    check("drain_req_valid", imem_req_valid, 0);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check("rdw_req_valid", imem_req_valid, 1);
    check("rdw_req_addr", imem_req_addr, 32'h2000);
    check("rdw_inst_valid", inst_valid, 0);
    check("rdw_inst_data", inst_data, 32'hCAFE_F00D);

    // Fetch at 0x2000, then redirect coinciding with response at 0x2004
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    step();
    imem_rsp_valid = 1'b0;
    step();
    check("req3_addr", imem_req_addr, 32'h2004);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_3333;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    #1;
    check("rdr_pc_en", pc_en, 1);
    check("rdr_next_pc", next_pc, 32'h2000);
    step();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rdr_req_valid", imem_req_valid, 1);
    check("rdr_req_addr", imem_req_addr, 32'h2000);
    check("rdr_inst_valid", inst_valid, 0);
    check("rdr_inst_data", inst_data, 32'h2222_2222);

    // Redirect in REQ (not accepted), then PC wraps past 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    check("wrap_req_valid", imem_req_valid, 1);
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4444_4444;
    #1;
    check("wrap_next_pc", next_pc, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_addr0", imem_req_addr, 32'h0);

    // Redirect in REQ while the request is accepted -> DRAIN
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rdq_drain_req", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h6666_6666;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    check("rdq_req_valid", imem_req_valid, 1);
    check("rdq_req_addr", imem_req_addr, 32'h3000);
    check("rdq_inst_valid", inst_valid, 0);

    // Reset mid-operation (in WAIT)
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mrst_pc_en", pc_en, 0);
    check("mrst_req_valid", imem_req_valid, 0);
    step();
    check("mrst_inst_data", inst_data, 0);
    reset_n = 1'b1;
    #1;
    check("mrst_boot_pc_en", pc_en, 1);
    check("mrst_boot_next_pc", next_pc, 32'h100);
    step();
    check("mrst_req_addr", imem_req_addr, 32'h100);

`ifdef FETCH_TIMEOUT_EN
    // Timeout after 8 WAIT cycles, HALT ignores redirects, reset clears fault
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("tmo_fault_early", fetch_fault, 0);
    check("tmo_wait_req", imem_req_valid, 0);
    step();
    check("tmo_fault", fetch_fault, 1);
    check("tmo_halt_req", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    #1;
    check("halt_rd_pc_en", pc_en, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("halt_req_valid", imem_req_valid, 0);
    check("halt_fault", fetch_fault, 1);
    reset_n = 1'b0;
    step();
    check("tmo_rst_fault", fetch_fault, 0);
    reset_n = 1'b1;
    #1;
    check("tmo_boot_next_pc", next_pc, 32'h100);
    step();
    check("tmo_req_addr", imem_req_addr, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
